// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Holds one operation in flight: accept, execute for one cycle, then hold the response until it is consumed.
module alu_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_OP     = 4
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  Req0_Valid_i,
   output logic                  Req0_Ready_o,
   input  logic [3:0]            Req0_Op_i,
   input  logic [DATA_WIDTH-1:0] Req0_A_i,
   input  logic [DATA_WIDTH-1:0] Req0_B_i,

   input  logic                  Req1_Valid_i,
   output logic                  Req1_Ready_o,
   input  logic [3:0]            Req1_Op_i,
   input  logic [DATA_WIDTH-1:0] Req1_A_i,
   input  logic [DATA_WIDTH-1:0] Req1_B_i,

   output logic [3:0]            ALU_Operation_o,
   output logic [DATA_WIDTH-1:0] ALU_A_o,
   output logic [DATA_WIDTH-1:0] ALU_B_o,
   input  logic [DATA_WIDTH-1:0] ALU_Result_i,
   input  logic                  ALU_Zero_i,

   output logic                  Rsp_Valid_o,
   input  logic                  Rsp_Ready_i,
   output logic                  Rsp_Id_o,
   output logic [DATA_WIDTH-1:0] Rsp_Result_o,
   output logic                  Rsp_Zero_o,
   output logic                  Rsp_Err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic   last_grant;
   logic   grant0;
   logic   grant1;
   logic   op_illegal;

   // A requester wins when the other is idle or was served last; the two grants are mutually exclusive.
   assign grant0 = Req0_Valid_i & (~Req1_Valid_i | last_grant);
   assign grant1 = Req1_Valid_i & (~Req0_Valid_i | ~last_grant);

   assign Req0_Ready_o = (state == IDLE) & grant0;
   assign Req1_Ready_o = (state == IDLE) & grant1;

   assign op_illegal = 32'(ALU_Operation_o) > 32'(MAX_OP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         last_grant      <= 1'b1;
         ALU_Operation_o <= '0;
         ALU_A_o         <= '0;
         ALU_B_o         <= '0;
         Rsp_Valid_o     <= 1'b0;
         Rsp_Id_o        <= 1'b0;
         Rsp_Result_o    <= '0;
         Rsp_Zero_o      <= 1'b0;
         Rsp_Err_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0) begin
                  ALU_Operation_o <= Req0_Op_i;
                  ALU_A_o         <= Req0_A_i;
                  ALU_B_o         <= Req0_B_i;
                  Rsp_Id_o        <= 1'b0;
                  last_grant      <= 1'b0;
                  state           <= EXEC;
               end else if (grant1) begin
                  ALU_Operation_o <= Req1_Op_i;
                  ALU_A_o         <= Req1_A_i;
                  ALU_B_o         <= Req1_B_i;
                  Rsp_Id_o        <= 1'b1;
                  last_grant      <= 1'b1;
                  state           <= EXEC;
               end
            end
            EXEC: begin
               Rsp_Result_o <= ALU_Result_i;
               Rsp_Zero_o   <= ALU_Zero_i;
               Rsp_Err_o    <= op_illegal;
               Rsp_Valid_o  <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               // Returning to IDLE on the consume edge keeps a new grant out of that same cycle.
               if (Rsp_Ready_i) begin
                  Rsp_Valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               Rsp_Valid_o <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
